dozator_tx_arbiter: RTL and testbench
=====================================

DOZATOR_TX_ARBITER -- requirements
Module: DOZATOR_TX_ARBITER

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of dozator channels served (legal range 2..4).
REQ-002 SHALL have parameter IFG_CYCLES, default 12, idle cycles inserted between frames.
REQ-003 SHALL have parameter WDT_CYCLES, default 4096, REQ-state watchdog limit in cycles.
REQ-004 SHALL have port CLK  in  1  single clock; all logic on posedge CLK.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port CH_RDY  in  CH_NUM  per-channel "packet buffered" flag from each dozator.
REQ-007 SHALL have port CH_REQUEST  out  CH_NUM  per-channel read request, one-hot pulse.
REQ-008 SHALL have port CH_DATA  in  8*CH_NUM  per-channel byte stream; channel i at bits [8i+7:8i].
REQ-009 SHALL have port CH_VLD  in  CH_NUM  per-channel byte valid.
REQ-010 SHALL have port CH_LENGTH  in  16*CH_NUM  per-channel payload byte count.
REQ-011 SHALL have port CH_CHECKSUM  in  16*CH_NUM  per-channel payload checksum.
REQ-012 SHALL have port TX_READY  in  1  downstream UDP framer can accept a new frame.
REQ-013 SHALL have port TX_START  out  1  one-cycle frame start pulse to the framer.
REQ-014 SHALL have port TX_CH_ID  out  2  index of the granted channel.
REQ-015 SHALL have port TX_LENGTH  out  16  latched CH_LENGTH of the granted channel.
REQ-016 SHALL have port TX_CHECKSUM  out  16  latched CH_CHECKSUM of the granted channel.
REQ-017 SHALL have port TX_DATA / TX_DATA_VLD  out  8 / 1  muxed byte stream from the granted channel.
REQ-018 SHALL have port ERR_FLAGS  out  2  one-cycle pulses: bit0 watchdog timeout, bit1 length mismatch.

Function
REQ-019 SHALL implement an FSM with states IDLE, ARB, REQ, STREAM and GAP.
REQ-020 SHALL go from IDLE to ARB only when TX_READY=1 and at least one CH_RDY bit is 1; TX_READY is ignored in all other states.
REQ-021 SHALL, in ARB, grant by round-robin: the first set CH_RDY bit strictly after the last-granted index, with wrap-around.
REQ-022 SHALL, in ARB, latch TX_CH_ID, TX_LENGTH and TX_CHECKSUM from the granted channel, then go to REQ.
REQ-023 SHALL, on the first REQ cycle, assert CH_REQUEST[grant] and TX_START together for exactly one cycle.
REQ-024 SHALL, in REQ, go to STREAM on CH_VLD[grant]=1; after WDT_CYCLES cycles without it, pulse ERR_FLAGS[0] and go to GAP.
REQ-025 SHALL register CH_DATA[grant]/CH_VLD[grant] to TX_DATA/TX_DATA_VLD with 1-cycle latency, including the byte that triggered the REQ->STREAM transition.
REQ-026 SHALL, in STREAM, count valid bytes in a 16-bit counter that saturates at 0xFFFF.
REQ-027 SHALL end STREAM on the first cycle CH_VLD[grant]=0, then go to GAP.
REQ-028 SHALL, on leaving STREAM, pulse ERR_FLAGS[1] if the count differs from TX_LENGTH+4 (4 header bytes).
REQ-029 SHALL hold TX_DATA_VLD=0 in GAP for max(IFG_CYCLES,1) cycles, then return to IDLE.
REQ-030 SHALL ignore CH_VLD and CH_DATA of non-granted channels, and changes on CH_RDY after ARB.
REQ-031 SHALL, in ARB, use CH_RDY as sampled in that ARB cycle when several bits are set in the same cycle.
REQ-032 SHALL keep TX_CH_ID/TX_LENGTH/TX_CHECKSUM stable from ARB exit until the next ARB.

Reset
REQ-033 SHALL, while RST=1 at a CLK edge, set the FSM to IDLE and all outputs to 0, including mid-frame.
REQ-034 SHALL, on reset, set the last-grant pointer to CH_NUM-1 so that channel 0 wins the first arbitration.

Configuration
REQ-035 SHALL, with macro DOZATOR_ARB_STRICT_PRIORITY_EN defined, replace round-robin with fixed priority: lowest set CH_RDY index wins.
REQ-036 SHALL, without DOZATOR_ARB_STRICT_PRIORITY_EN, use round-robin per REQ-021.

Verification
REQ-037 SHALL cover: CH_RDY=4'b0101, TX_READY=1 -> grant ch0, then ch2, then ch0, each with one TX_START pulse.
REQ-038 SHALL cover: ch1 CH_LENGTH=64, streams 68 bytes -> TX_DATA matches 1 cycle later, ERR_FLAGS=0, then 12 gap cycles.
REQ-039 SHALL cover: ch3 streams 67 bytes with CH_LENGTH=64 -> ERR_FLAGS[1] pulses once at STREAM exit.
REQ-040 SHALL cover: granted channel never asserts CH_VLD -> ERR_FLAGS[0] pulses at cycle 4096, FSM passes through GAP to IDLE.
REQ-041 SHALL cover: RST asserted mid-STREAM -> next edge all outputs 0, after release channel 0 granted first.
REQ-042 SHALL cover: with DOZATOR_ARB_STRICT_PRIORITY_EN, CH_RDY held 4'b1111 -> ch0 granted every frame.

Source files
------------

// File: rtl/dozator_tx_arbiter.sv
// Arbitrates up to four dozator packet buffers onto one UDP framer: grant, request, stream, gap.
// Define DOZATOR_ARB_STRICT_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module dozator_tx_arbiter #(
  parameter int CH_NUM     = 4,
  parameter int IFG_CYCLES = 12,
  parameter int WDT_CYCLES = 4096
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CH_NUM-1:0]      CH_RDY,
  output logic [CH_NUM-1:0]      CH_REQUEST,
  input  logic [8*CH_NUM-1:0]    CH_DATA,
  input  logic [CH_NUM-1:0]      CH_VLD,
  input  logic [16*CH_NUM-1:0]   CH_LENGTH,
  input  logic [16*CH_NUM-1:0]   CH_CHECKSUM,
  input  logic                   TX_READY,
  output logic                   TX_START,
  output logic [1:0]             TX_CH_ID,
  output logic [15:0]            TX_LENGTH,
  output logic [15:0]            TX_CHECKSUM,
  output logic [7:0]             TX_DATA,
  output logic                   TX_DATA_VLD,
  output logic [1:0]             ERR_FLAGS
);

  localparam int GAP_LEN = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
  localparam int WDT_W   = $clog2(WDT_CYCLES + 1);
  localparam int GAP_W   = $clog2(GAP_LEN + 1);
  localparam int IDX_W   = $clog2(CH_NUM);

  typedef enum logic [2:0] {IDLE, ARB, REQ, STREAM, GAP} state_t;

  state_t             state, state_n;
  logic [1:0]         last_grant, grant_idx;
  logic               grant_found;
  logic               start_frame, wdt_expire, stream_end;
  logic [WDT_W-1:0]   wdt_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [15:0]        byte_cnt;
  logic               ch_vld_g;
  logic [7:0]         ch_data_g;
  logic               len_mismatch;

  // Only the granted channel is ever looked at once a frame is under way.
  assign ch_vld_g     = CH_VLD[IDX_W'(TX_CH_ID)];
  assign ch_data_g    = CH_DATA[8*TX_CH_ID +: 8];
  assign len_mismatch = ({1'b0, byte_cnt} != ({1'b0, TX_LENGTH} + 17'd4));

`ifdef DOZATOR_ARB_STRICT_PRIORITY_EN
  always_comb begin : arb_sel
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (CH_RDY[IDX_W'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(k);
      end
    end
  end
`else
  always_comb begin : arb_sel
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    // Scan from the farthest offset down so the nearest ready channel after last_grant wins.
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % CH_NUM;
      if (CH_RDY[IDX_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = 2'(idx);
      end
    end
  end
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    wdt_expire  = 1'b0;
    stream_end  = 1'b0;
    unique case (state)
      IDLE:   if (TX_READY && |CH_RDY) state_n = ARB;
      ARB: begin
        if (grant_found) begin
          start_frame = 1'b1;
          state_n     = REQ;
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        if (ch_vld_g) begin
          state_n = STREAM;
        end else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
          wdt_expire = 1'b1;
          state_n    = GAP;
        end
      end
      STREAM: begin
        if (!ch_vld_g) begin
          stream_end = 1'b1;
          state_n    = GAP;
        end
      end
      GAP:     if (gap_cnt == GAP_W'(GAP_LEN - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant  <= 2'(CH_NUM - 1);
      CH_REQUEST  <= '0;
      TX_START    <= 1'b0;
      TX_CH_ID    <= '0;
      TX_LENGTH   <= '0;
      TX_CHECKSUM <= '0;
      TX_DATA     <= '0;
      TX_DATA_VLD <= 1'b0;
      ERR_FLAGS   <= '0;
      wdt_cnt     <= '0;
      gap_cnt     <= '0;
      byte_cnt    <= '0;
    end else begin
      TX_START   <= start_frame;
      CH_REQUEST <= start_frame ? (CH_NUM'(1) << grant_idx) : '0;
      ERR_FLAGS  <= {stream_end && len_mismatch, wdt_expire};

      if (start_frame) begin
        last_grant  <= grant_idx;
        TX_CH_ID    <= grant_idx;
        TX_LENGTH   <= CH_LENGTH[16*grant_idx +: 16];
        TX_CHECKSUM <= CH_CHECKSUM[16*grant_idx +: 16];
      end

      wdt_cnt <= (state == REQ) ? wdt_cnt + 1'b1 : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;

      if (state == REQ || state == STREAM) begin
        TX_DATA     <= ch_data_g;
        TX_DATA_VLD <= ch_vld_g;
      end else begin
        TX_DATA_VLD <= 1'b0;
      end

      // The byte that moves REQ to STREAM is the first one counted.
      if (state == REQ)
        byte_cnt <= {15'd0, ch_vld_g};
      else if (state == STREAM && ch_vld_g && byte_cnt != 16'hFFFF)
        byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dozator_tx_arbiter.sv
// Randomized scoreboard bench for dozator_tx_arbiter: a reference grant model plus
// emulated dozators feed expected frames, bytes and error pulses to a negedge monitor.
module tb_dozator_tx_arbiter;

  localparam int CH_NUM = 4;
  localparam int IFG    = 12;
  localparam int WDT    = 4096;
  localparam int GAP    = (IFG < 1) ? 1 : IFG;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [CH_NUM-1:0]    CH_RDY, CH_REQUEST, CH_VLD;
  logic [8*CH_NUM-1:0]  CH_DATA;
  logic [16*CH_NUM-1:0] CH_LENGTH, CH_CHECKSUM;
  logic                 TX_READY, TX_START, TX_DATA_VLD;
  logic [1:0]           TX_CH_ID, ERR_FLAGS;
  logic [15:0]          TX_LENGTH, TX_CHECKSUM;
  logic [7:0]           TX_DATA;

  dozator_tx_arbiter #(.CH_NUM(CH_NUM), .IFG_CYCLES(IFG), .WDT_CYCLES(WDT)) dut (
    .CLK(CLK), .RST(RST), .CH_RDY(CH_RDY), .CH_REQUEST(CH_REQUEST), .CH_DATA(CH_DATA),
    .CH_VLD(CH_VLD), .CH_LENGTH(CH_LENGTH), .CH_CHECKSUM(CH_CHECKSUM), .TX_READY(TX_READY),
    .TX_START(TX_START), .TX_CH_ID(TX_CH_ID), .TX_LENGTH(TX_LENGTH), .TX_CHECKSUM(TX_CHECKSUM),
    .TX_DATA(TX_DATA), .TX_DATA_VLD(TX_DATA_VLD), .ERR_FLAGS(ERR_FLAGS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int id; logic [15:0] len; logic [15:0] ck; int cyc; } frame_t;
  typedef struct { logic [7:0] d; int cyc; } byte_t;
  typedef struct { logic [1:0] f; int cyc; } err_t;

  frame_t exp_frames[$];
  byte_t  exp_bytes[$];
  err_t   exp_errs[$];

  int last_grant_m = CH_NUM - 1;
  int next_start   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s @cyc %0d: got an output event, expected none", name, cyc);
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Reference arbitration: which ready channel should win, given the last winner.
  function automatic int model_grant(input logic [3:0] rdy, input int last);
`ifdef DOZATOR_ARB_STRICT_PRIORITY_EN
    for (int i = 0; i < CH_NUM; i++) if (rdy[i]) return i;
`else
    for (int k = 1; k <= CH_NUM; k++) if (rdy[(last + k) % CH_NUM]) return (last + k) % CH_NUM;
`endif
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a start, a byte or an error.
  frame_t      mf;
  byte_t       mb;
  err_t        me;
  int          cur_id  = 0;
  logic [15:0] cur_len = '0;
  logic [15:0] cur_ck  = '0;

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (TX_START === 1'b1) begin
        if (exp_frames.size() == 0) flag_fail("unexpected_start");
        else begin
          mf = exp_frames.pop_front();
          check("grant_id",     TX_CH_ID,    mf.id);
          check("tx_length",    TX_LENGTH,   mf.len);
          check("tx_checksum",  TX_CHECKSUM, mf.ck);
          check("ch_request",   CH_REQUEST,  64'(1) << mf.id);
          check("start_cycle",  cyc,         mf.cyc);
          cur_id  = mf.id;
          cur_len = mf.len;
          cur_ck  = mf.ck;
        end
      end else begin
        check("request_quiet", CH_REQUEST, 0);
      end
      if (TX_DATA_VLD !== 1'b0) begin
        if (exp_bytes.size() == 0) flag_fail("unexpected_byte");
        else begin
          mb = exp_bytes.pop_front();
          check("tx_data",      TX_DATA,     mb.d);
          check("byte_cycle",   cyc,         mb.cyc);
          check("id_stable",    TX_CH_ID,    cur_id);
          check("len_stable",   TX_LENGTH,   cur_len);
          check("ck_stable",    TX_CHECKSUM, cur_ck);
        end
      end
      if (ERR_FLAGS !== 2'b00) begin
        if (exp_errs.size() == 0) flag_fail("unexpected_err");
        else begin
          me = exp_errs.pop_front();
          check("err_flags", ERR_FLAGS, me.f);
          check("err_cycle", cyc,       me.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Channel g carries the real stream; every other channel carries noise.
  task automatic drive_lines(input int g, input bit v, input logic [7:0] d);
    for (int i = 0; i < CH_NUM; i++) begin
      if (i == g) begin
        CH_VLD[i]        = v;
        CH_DATA[8*i +: 8] = d;
      end else begin
        CH_VLD[i]        = 1'($urandom);
        CH_DATA[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic scramble_cfg();
    CH_LENGTH   = {$urandom, $urandom};
    CH_CHECKSUM = {$urandom, $urandom};
    CH_RDY      = 4'($urandom);
    TX_READY    = 1'($urandom);
  endtask

  task automatic wait_start(input int budget, output int s);
    s = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (TX_START === 1'b1) begin
        s = cyc;
        break;
      end
      drive_lines(-1, 1'b0, 8'h00);
    end
    if (s < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_timeout @cyc %0d: got no TX_START, expected one by cyc %0d", cyc, next_start);
      finish_test();
    end
  endtask

  // One full frame: arbitration expectation, dozator emulation, length/watchdog outcome.
  task automatic run_frame(input logic [3:0] rdy, input int len, input int n, input int delay,
                           input bit wdt, input int hold);
    int g, s, end_cyc;
    logic [7:0] d;
    if (hold > 0) begin
      TX_READY = 1'b0;
      while (cyc < next_start - 2 + hold) begin
        CH_RDY = 4'($urandom);
        drive_lines(-1, 1'b0, 8'h00);
        tick();
      end
      TX_READY   = 1'b1;
      next_start = cyc + 2;
    end
    CH_RDY      = rdy;
    CH_LENGTH   = {$urandom, $urandom};
    CH_CHECKSUM = {$urandom, $urandom};
    g = model_grant(rdy, last_grant_m);
    last_grant_m = g;
    CH_LENGTH[16*g +: 16] = 16'(len);
    exp_frames.push_back('{g, 16'(len), CH_CHECKSUM[16*g +: 16], next_start});
    wait_start(next_start - cyc + 40, s);
    if (wdt) begin
      while (cyc < s + WDT) begin
        scramble_cfg();
        drive_lines(g, 1'b0, 8'h00);
        tick();
      end
      TX_READY = 1'b1;
      exp_errs.push_back('{2'b01, s + WDT});
      end_cyc = s + WDT - 1;
    end else begin
      end_cyc = s;
      for (int k = 0; k <= delay + n; k++) begin
        scramble_cfg();
        if (k < delay) begin
          drive_lines(g, 1'b0, 8'h00);
        end else if (k < delay + n) begin
          d = 8'($urandom);
          drive_lines(g, 1'b1, d);
          exp_bytes.push_back('{d, cyc + 1});
        end else begin
          drive_lines(g, 1'b0, 8'h00);
          TX_READY = 1'b1;
          end_cyc  = cyc;
          if (n != len + 4) exp_errs.push_back('{2'b10, cyc + 1});
        end
        tick();
      end
    end
    next_start = end_cyc + GAP + 3;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"},    TX_START,    0);
    check({tag, "_request"},  CH_REQUEST,  0);
    check({tag, "_ch_id"},    TX_CH_ID,    0);
    check({tag, "_length"},   TX_LENGTH,   0);
    check({tag, "_checksum"}, TX_CHECKSUM, 0);
    check({tag, "_data"},     TX_DATA,     0);
    check({tag, "_data_vld"}, TX_DATA_VLD, 0);
    check({tag, "_err"},      ERR_FLAGS,   0);
  endtask

  initial begin
    int g, s, len, n;
    logic [7:0] d;
    RST = 1'b1; TX_READY = 1'b0; CH_RDY = '0; CH_VLD = '0; CH_DATA = '0;
    CH_LENGTH = '0; CH_CHECKSUM = '0;
    repeat (3) tick();
    check_outputs_zero("reset");

    RST        = 1'b0;
    TX_READY   = 1'b1;
    next_start = cyc + 2;

    // Two ready channels alternate 0, 2, 0.
    for (int i = 0; i < 3; i++) run_frame(4'b0101, 8, 12, $urandom_range(0, 2), 1'b0, 0);
    // Length 64 with 68 bytes is clean; 67 bytes is a mismatch.
    run_frame(4'b0010, 64, 68, 1, 1'b0, 0);
    run_frame(4'b1000, 64, 67, 0, 1'b0, 0);
    // All ready: round-robin cycles through, strict priority keeps channel 0.
    for (int i = 0; i < 4; i++) run_frame(4'b1111, 5, 9, 0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      len = $urandom_range(0, 24);
      n   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : len + 4;
      run_frame(4'($urandom_range(1, 15)), len, n, $urandom_range(0, 4), 1'b0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
    end

    // Granted channel stays silent: watchdog, then gap, then a normal frame.
    run_frame(4'b0100, 10, 0, 0, 1'b1, 0);
    run_frame(4'b0001, 3, 7, 0, 1'b0, 0);

    // Reset in the middle of a stream.
    CH_RDY      = 4'b0110;
    CH_LENGTH   = {$urandom, $urandom};
    CH_CHECKSUM = {$urandom, $urandom};
    g = model_grant(4'b0110, last_grant_m);
    exp_frames.push_back('{g, CH_LENGTH[16*g +: 16], CH_CHECKSUM[16*g +: 16], next_start});
    wait_start(next_start - cyc + 40, s);
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      drive_lines(g, 1'b1, d);
      exp_bytes.push_back('{d, cyc + 1});
      tick();
    end
    RST = 1'b1;
    drive_lines(g, 1'b1, 8'h5A);
    tick();
    check_outputs_zero("midreset");
    exp_frames.delete();
    exp_bytes.delete();
    exp_errs.delete();
    tick();
    RST          = 1'b0;
    TX_READY     = 1'b1;
    last_grant_m = CH_NUM - 1;
    next_start   = cyc + 2;
    run_frame(4'b1111, 2, 6, 0, 1'b0, 0);

    repeat (30) begin
      drive_lines(-1, 1'b0, 8'h00);
      tick();
    end
    check("frames_left", exp_frames.size(), 0);
    check("bytes_left",  exp_bytes.size(),  0);
    check("errs_left",   exp_errs.size(),   0);
    finish_test();
  end

endmodule
